// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for the 5-stage pipeline.
//
// Tracks destination-register info of the instructions in EX, MEM and WB, and
// from it derives load-use stalls, taken-branch/jump flushes, a whole-pipe
// freeze while data memory is busy, and EX-stage operand forwarding selects.
// A saturating counter accumulates stall and freeze cycles.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   id_valid          IF/ID holds a real instruction
//   id_rs, id_rt      source registers of the ID instruction
//   id_uses_rs/rt     ID instruction actually reads rs / rt
//   id_dst            destination register chosen by RegDst
//   id_regwrite       RegWrite from the decoder
//   id_memread        MemRead from the decoder; nonzero marks a load
//   ex_take           branch taken / jump resolved in EX
//   mem_busy          data memory not ready, MEM must hold
//   cnt_clr           clear the stall counter
//   pc_write          PC enable
//   ifid_write        IF/ID enable
//   ifid_flush        load a NOP into IF/ID
//   idex_bubble       load a NOP into ID/EX
//   pipe_en           enable for ID/EX, EX/MEM, MEM/WB
//   fwd_a, fwd_b      operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cycles      saturating stall/freeze cycle count
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic [1:0]       id_memread,
  input  logic             ex_take,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {
    StReset,
    StFreeze,
    StFlush,
    StLoadUse,
    StRun
  } mode_e;

  mode_e mode;

  // Shadow copies of the in-flight instructions' register usage
  logic [REG_W-1:0] ex_rs_q, ex_rt_q, ex_dst_q;
  logic             ex_rw_q, ex_load_q;
  logic [REG_W-1:0] mem_dst_q;
  logic             mem_rw_q;
  logic [REG_W-1:0] wb_dst_q;
  logic             wb_rw_q;

  logic [CNT_W-1:0] cnt_q;

  logic load_use;
  logic id_keep;

  // ex_rw_q is already zero for writes to register 0, so no separate r0 check
  assign load_use = id_valid & ex_load_q & ex_rw_q &
                    ((id_uses_rs & (id_rs == ex_dst_q)) |
                     (id_uses_rt & (id_rt == ex_dst_q)));

  always_comb begin
    mode = StRun;
    if (rst) begin
      mode = StReset;
    end else if (mem_busy) begin
      // EX holds its branch, so ex_take is seen again once memory is ready
      mode = StFreeze;
    end else if (ex_take) begin
      // The stalled younger instruction is squashed anyway
      mode = StFlush;
    end else if (load_use) begin
      mode = StLoadUse;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b1;
    unique case (mode)
      StReset: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        pipe_en     = 1'b0;
      end
      StFreeze: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_en    = 1'b0;
      end
      StFlush: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      StLoadUse: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // EX/MEM result is younger than MEM/WB, so it wins when both match
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (mem_rw_q && (mem_dst_q == src)) begin
      return 2'b10;
    end else if (wb_rw_q && (wb_dst_q == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(ex_rs_q);
      fwd_b = fwd_sel(ex_rt_q);
    end
  end

  assign id_keep = id_valid & ~idex_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      ex_dst_q  <= '0;
      ex_rw_q   <= 1'b0;
      ex_load_q <= 1'b0;
      mem_dst_q <= '0;
      mem_rw_q  <= 1'b0;
      wb_dst_q  <= '0;
      wb_rw_q   <= 1'b0;
    end else if (pipe_en) begin
      if (id_keep) begin
        ex_rs_q   <= id_rs;
        ex_rt_q   <= id_rt;
        ex_dst_q  <= id_dst;
        ex_rw_q   <= id_regwrite & (id_dst != '0);
        ex_load_q <= (id_memread != 2'b00);
      end else begin
        ex_rs_q   <= '0;
        ex_rt_q   <= '0;
        ex_dst_q  <= '0;
        ex_rw_q   <= 1'b0;
        ex_load_q <= 1'b0;
      end
      mem_dst_q <= ex_dst_q;
      mem_rw_q  <= ex_rw_q;
      wb_dst_q  <= mem_dst_q;
      wb_rw_q   <= mem_rw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (((mode == StFreeze) || (mode == StLoadUse)) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = cnt_q;

endmodule
